// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, FSM encoding and digit-wise helpers
// used by the counter/comparator and its digit slices.
package bcd_pkg;

  localparam int       BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int       MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // MSD-first compare: the first unequal digit decides, all-equal counts as >=.
  function automatic logic bcd_ge(input logic [31:0] a, input logic [31:0] b,
                                  input int digits);
    logic decided;
    logic ge;
    decided = 1'b0;
    ge      = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < digits && !decided && a[4*i +: 4] != b[4*i +: 4]) begin
        decided = 1'b1;
        ge      = a[4*i +: 4] > b[4*i +: 4];
      end
    end
    return ge;
  endfunction

  function automatic logic bcd_valid(input logic [31:0] v, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && v[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_count_compare_if.sv
// Control/status bundle between the keypad/threshold side and the
// BCD counter/comparator.
interface bcd_count_compare_if #(parameter int DIGITS = 4);

  logic [4*DIGITS-1:0] thr;
  logic                load;
  logic                start;
  logic                stop;
  logic                mode;
  logic [4*DIGITS-1:0] cnt;
  logic                hit;
  logic                done;
  logic                busy;
  logic                err;

  modport master (
    output thr, load, start, stop, mode,
    input  cnt, hit, done, busy, err
  );

  modport slave (
    input  thr, load, start, stop, mode,
    output cnt, hit, done, busy, err
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple counter: counts 0..9 when enabled and the
// carry-in is set, and raises carry-out while passing 9.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && cin) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

  assign cout = cin && (q == BCD_MAX);

endmodule

// File: rtl/bcd_count_compare.sv
// N-digit BCD up-counter with loadable threshold, MSD-first BCD compare and
// a one-cycle DONE pulse per match; MODE selects hold or auto-restart.
module bcd_count_compare
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_count_compare_if.slave bus
);

  localparam int W = BCD_W * DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   thr_q, thr_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           cnt_clr, cnt_inc;
  logic [W-1:0]   cnt_q;
  logic [DIGITS:0] carry;
  logic           hit;
  logic           thr_ok;
  logic           can_load;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_inc),
      .cin   (carry[i]),
      .q     (cnt_q[BCD_W*i +: BCD_W]),
      .cout  (carry[i+1])
    );
  end

  assign hit      = bcd_ge(32'(cnt_q), 32'(thr_q), DIGITS);
  assign thr_ok   = bcd_valid(32'(bus.thr), DIGITS);
  assign can_load = (state_q != RUN);

  // Priority STOP > START > LOAD, except a START+LOAD pair outside RUN where
  // the load is judged first and an invalid threshold drops the start.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    thr_d   = thr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start && bus.load && can_load) begin
      if (thr_ok) begin
        thr_d   = bus.thr;
        err_d   = 1'b0;
        cnt_clr = 1'b1;
        state_d = RUN;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.start && !err_q) begin
      cnt_clr = 1'b1;
      state_d = RUN;
    end else if (bus.load && can_load) begin
      if (thr_ok) begin
        thr_d = bus.thr;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (hit) begin
        done_d = 1'b1;
        if (bus.mode) cnt_clr = 1'b1;
        else          state_d = HOLD;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      thr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.hit  = hit;
  assign bus.done = done_q;
  assign bus.busy = (state_q == RUN);
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_count_compare.sv
// Bench for bcd_count_compare: integer-level reference model checked every
// cycle on a 4-digit and a 2-digit instance, plus directed literal checks.
module tb_bcd_count_compare;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_count_compare_if #(.DIGITS(4)) bus4 ();
  bcd_count_compare_if #(.DIGITS(2)) bus2 ();

  bcd_count_compare #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  bcd_count_compare #(.DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts and thresholds kept as plain integers.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  typedef struct {
    int cnt;
    int thr;
    int st;
    bit done;
    bit err;
  } model_t;

  model_t m4, m2;

  function automatic bit digits_ok(input logic [31:0] v, input int digits);
    for (int i = 0; i < digits; i++)
      if (((v >> (4*i)) & 32'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int to_int(input logic [31:0] v, input int digits);
    int r = 0;
    for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'((v >> (4*i)) & 32'hF);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic model_t step(input model_t m, input bit ld, input bit st, input bit sp,
                                  input bit md, input logic [31:0] thr, input int digits);
    model_t n = m;
    bit ok = digits_ok(thr, digits);
    n.done = 1'b0;
    if (sp) begin
      n.st = M_IDLE;
    end else if (st && ld && m.st != M_RUN) begin
      if (ok) begin
        n.thr = to_int(thr, digits); n.err = 1'b0; n.cnt = 0; n.st = M_RUN;
      end else n.err = 1'b1;
    end else if (st && !m.err) begin
      n.cnt = 0; n.st = M_RUN;
    end else if (ld && m.st != M_RUN) begin
      if (ok) begin n.thr = to_int(thr, digits); n.err = 1'b0; end
      else n.err = 1'b1;
    end else if (m.st == M_RUN) begin
      if (m.cnt >= m.thr) begin
        n.done = 1'b1;
        if (md) n.cnt = 0;
        else    n.st = M_HOLD;
      end else n.cnt = (m.cnt + 1) % (10 ** digits);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '{cnt: 0, thr: 0, st: M_IDLE, done: 1'b0, err: 1'b0};
      m2 <= '{cnt: 0, thr: 0, st: M_IDLE, done: 1'b0, err: 1'b0};
    end else begin
      m4 <= step(m4, bus4.load, bus4.start, bus4.stop, bus4.mode, 32'(bus4.thr), 4);
      m2 <= step(m2, bus2.load, bus2.start, bus2.stop, bus2.mode, 32'(bus2.thr), 2);
    end
  end

  always @(negedge clk) begin
    check("m4_cnt",  32'(bus4.cnt),  to_bcd(m4.cnt));
    check("m4_hit",  32'(bus4.hit),  32'(m4.cnt >= m4.thr));
    check("m4_done", 32'(bus4.done), 32'(m4.done));
    check("m4_busy", 32'(bus4.busy), 32'(m4.st == M_RUN));
    check("m4_err",  32'(bus4.err),  32'(m4.err));
    check("m2_cnt",  32'(bus2.cnt),  to_bcd(m2.cnt));
    check("m2_hit",  32'(bus2.hit),  32'(m2.cnt >= m2.thr));
    check("m2_done", 32'(bus2.done), 32'(m2.done));
    check("m2_busy", 32'(bus2.busy), 32'(m2.st == M_RUN));
    check("m2_err",  32'(bus2.err),  32'(m2.err));
  end

  // Called at a falling edge; inputs are sampled by the next rising edge.
  task automatic drive4(input bit ld, input bit st, input bit sp, input logic [15:0] t);
    bus4.load = ld; bus4.start = st; bus4.stop = sp; bus4.thr = t;
    @(negedge clk);
    bus4.load = 1'b0; bus4.start = 1'b0; bus4.stop = 1'b0;
  endtask

  task automatic drive2(input bit ld, input bit st, input bit sp, input logic [7:0] t);
    bus2.load = ld; bus2.start = st; bus2.stop = sp; bus2.thr = t;
    @(negedge clk);
    bus2.load = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0;
  endtask

  int first_done;
  int n_done;
  int exp_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus4.thr = '0; bus4.load = 1'b0; bus4.start = 1'b0; bus4.stop = 1'b0; bus4.mode = 1'b0;
    bus2.thr = '0; bus2.load = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0; bus2.mode = 1'b0;

    #12;
    check("rst_cnt",  32'(bus4.cnt),  32'h0);
    check("rst_hit",  32'(bus4.hit),  32'h1);
    check("rst_done", 32'(bus4.done), 32'h0);
    check("rst_busy", 32'(bus4.busy), 32'h0);
    check("rst_err",  32'(bus4.err),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // MODE 0 run to 1234
    drive4(1'b1, 1'b0, 1'b0, 16'h1234);
    drive4(1'b0, 1'b1, 1'b0, 16'h0000);
    check("t1_start_cnt",  32'(bus4.cnt),  32'h0);
    check("t1_start_busy", 32'(bus4.busy), 32'h1);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 1240; k++) begin
      @(negedge clk);
      if (k == 1234) check("t1_cnt_at_T", 32'(bus4.cnt), 32'h1234);
      if (bus4.done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    check("t1_done_edge",  32'(first_done), 32'd1235);
    check("t1_done_count", 32'(n_done),     32'd1);
    check("t1_hold_cnt",   32'(bus4.cnt),   32'h1234);
    check("t1_hold_busy",  32'(bus4.busy),  32'h0);
    check("t1_hold_hit",   32'(bus4.hit),   32'h1);

    // MODE 1 with threshold 3
    bus4.mode = 1'b1;
    drive4(1'b1, 1'b1, 1'b0, 16'h0003);
    check("t2_start_cnt", 32'(bus4.cnt), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t2_cnt",  32'(bus4.cnt),  32'(exp_seq[k-1]));
      check("t2_done", 32'(bus4.done), 32'((k % 4) == 0));
    end
    drive4(1'b0, 1'b0, 1'b1, 16'h0000);
    check("t2_stop_busy", 32'(bus4.busy), 32'h0);
    check("t2_stop_cnt",  32'(bus4.cnt),  32'h0);
    bus4.mode = 1'b0;

    // invalid threshold, ignored start, recovery
    drive4(1'b1, 1'b0, 1'b0, 16'h12A4);
    check("t3_err_set", 32'(bus4.err), 32'h1);
    check("t3_hit_old", 32'(bus4.hit), 32'h0);
    drive4(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    check("t3_start_ignored", 32'(bus4.busy), 32'h0);
    drive4(1'b1, 1'b0, 1'b0, 16'h0009);
    check("t3_err_clear", 32'(bus4.err), 32'h0);

    // START+LOAD from HOLD retargets the run
    drive4(1'b1, 1'b1, 1'b0, 16'h0050);
    repeat (55) @(negedge clk);
    check("t4_hold50_cnt",  32'(bus4.cnt),  32'h0050);
    check("t4_hold50_busy", 32'(bus4.busy), 32'h0);
    drive4(1'b1, 1'b1, 1'b0, 16'h0002);
    first_done = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus4.done && first_done == 0) first_done = k;
    end
    check("t4_done_edge", 32'(first_done), 32'd3);
    check("t4_cnt",       32'(bus4.cnt),   32'h0002);

    // two digits: carries, DONE at edge 100, then STOP at 45
    drive2(1'b1, 1'b1, 1'b0, 8'h99);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      if (k == 9)  check("t5_cnt09", 32'(bus2.cnt), 32'h09);
      if (k == 10) check("t5_cnt10", 32'(bus2.cnt), 32'h10);
      if (k == 89) check("t5_cnt89", 32'(bus2.cnt), 32'h89);
      if (k == 90) check("t5_cnt90", 32'(bus2.cnt), 32'h90);
      if (bus2.done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    check("t5_done_edge",  32'(first_done), 32'd100);
    check("t5_done_count", 32'(n_done),     32'd1);
    check("t5_hold_cnt",   32'(bus2.cnt),   32'h99);
    drive2(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (45) @(negedge clk);
    check("t5_cnt45", 32'(bus2.cnt), 32'h45);
    drive2(1'b0, 1'b0, 1'b1, 8'h00);
    n_done = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus2.done) n_done++;
    end
    check("t5_stop_nodone", 32'(n_done),    32'd0);
    check("t5_stop_cnt",    32'(bus2.cnt),  32'h45);
    check("t5_stop_busy",   32'(bus2.busy), 32'h0);

    // asynchronous reset mid-run
    drive4(1'b1, 1'b1, 1'b0, 16'h1000);
    repeat (517) @(negedge clk);
    check("t6_cnt0517", 32'(bus4.cnt), 32'h0517);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cnt",  32'(bus4.cnt),  32'h0);
    check("t6_rst_hit",  32'(bus4.hit),  32'h1);
    check("t6_rst_done", 32'(bus4.done), 32'h0);
    check("t6_rst_busy", 32'(bus4.busy), 32'h0);
    check("t6_rst_err",  32'(bus4.err),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b0, 1'b1, 1'b0, 16'h0000);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus4.done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    check("t6_done_edge",  32'(first_done), 32'd1);
    check("t6_done_count", 32'(n_done),     32'd1);
    check("t6_cnt",        32'(bus4.cnt),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
